// File: rtl/m_upload_pkg.sv
// Shared types and constants for the memory-reply upload block (state codes,
// flit ctrl codes, message geometry, length clamp).
package m_upload_pkg;

  localparam int FLIT_W    = 16;
  localparam int MAX_FLITS = 11;
  localparam int MIN_FLITS = 2;
  localparam int MSG_W     = FLIT_W * MAX_FLITS;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CTRL_NONE = 2'b00,
    CTRL_HEAD = 2'b01,
    CTRL_BODY = 2'b10,
    CTRL_TAIL = 2'b11
  } ctrl_t;

  // Requested length forced into the legal head+tail..full-message range.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    if (len < CNT_W'(MIN_FLITS))      return CNT_W'(MIN_FLITS);
    else if (len > CNT_W'(MAX_FLITS)) return CNT_W'(MAX_FLITS);
    else                              return len;
  endfunction

endpackage

// File: rtl/m_upload_if.sv
// Memory-reply request side plus ring-facing flit output of m_upload.
// master = memory/ring environment, slave = m_upload.
interface m_upload_if;
  import m_upload_pkg::*;

  logic              v_m_upload_req;
  logic [MSG_W-1:0]  m_upload_flits;
  logic [CNT_W-1:0]  m_upload_len;
  logic              net_rdy;
  logic              m_upload_ack;
  logic [FLIT_W-1:0] OUT_flit_mem;
  logic              v_OUT_flit_mem;
  logic [1:0]        OUT_flit_ctrl;
  logic              m_upload_done;
  logic [1:0]        m_upload_state;

  modport master (
    output v_m_upload_req, m_upload_flits, m_upload_len, net_rdy,
    input  m_upload_ack, OUT_flit_mem, v_OUT_flit_mem, OUT_flit_ctrl,
           m_upload_done, m_upload_state
  );

  modport slave (
    input  v_m_upload_req, m_upload_flits, m_upload_len, net_rdy,
    output m_upload_ack, OUT_flit_mem, v_OUT_flit_mem, OUT_flit_ctrl,
           m_upload_done, m_upload_state
  );

endinterface

// File: rtl/m_upload.sv
// Captures a memory reply message and streams it onto the ring as head/body/tail flits.
// Build option: M_UPLOAD_BACKPRESSURE_EN makes flit transfer wait on net_rdy.
module m_upload
  import m_upload_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  m_upload_if.slave u
);

  state_t                            state;
  logic [CNT_W-1:0]                  cnt;
  logic [CNT_W-1:0]                  len_q;
  logic [MAX_FLITS-1:0][FLIT_W-1:0]  flit_q;
  logic                              ack_q;
  logic                              xfer;
  logic                              last;

`ifdef M_UPLOAD_BACKPRESSURE_EN
  assign xfer = u.net_rdy;
`else
  // Ring is assumed always ready; one flit leaves every busy cycle.
  logic unused_net_rdy;
  assign unused_net_rdy = u.net_rdy;
  assign xfer = 1'b1;
`endif

  assign last = (cnt == len_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      len_q  <= '0;
      flit_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: if (u.v_m_upload_req) begin
          flit_q <= u.m_upload_flits;
          len_q  <= eff_len(u.m_upload_len);
          cnt    <= '0;
          ack_q  <= 1'b1;
          state  <= ST_BUSY;
        end
        ST_BUSY: if (xfer) begin
          if (last) state <= ST_DONE;
          else      cnt   <= cnt + CNT_W'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flit outputs decode straight off the state/count registers so they hold
  // steady while the ring stalls.
  always_comb begin
    u.v_OUT_flit_mem = 1'b0;
    u.OUT_flit_mem   = '0;
    u.OUT_flit_ctrl  = CTRL_NONE;
    if (state == ST_BUSY) begin
      u.v_OUT_flit_mem = 1'b1;
      u.OUT_flit_mem   = flit_q[cnt];
      if (cnt == '0)  u.OUT_flit_ctrl = CTRL_HEAD;
      else if (last)  u.OUT_flit_ctrl = CTRL_TAIL;
      else            u.OUT_flit_ctrl = CTRL_BODY;
    end
  end

  assign u.m_upload_ack   = ack_q;
  assign u.m_upload_done  = (state == ST_DONE);
  assign u.m_upload_state = state;

endmodule

// File: tb/tb_m_upload.sv
// Directed bench for m_upload; covers both builds (M_UPLOAD_BACKPRESSURE_EN on/off).
module tb_m_upload;
  import m_upload_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  m_upload_if u ();

  m_upload dut (
    .clk (clk),
    .rst (rst),
    .u   (u)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MSG_W-1:0] build(input logic [15:0] base);
    logic [MSG_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_FLITS; k++) r[16*k +: 16] = base + 16'(k);
    return r;
  endfunction

  // Issues one request from idle and checks every flit, ack, done and return to idle.
  // With hold set, req stays high and alt data is driven while the first message streams.
  task automatic run_msg(input string tag, input logic [MSG_W-1:0] msg, input logic [3:0] len,
                         input int eff, input bit hold, input logic [MSG_W-1:0] alt,
                         input logic [3:0] alt_len);
    logic [1:0] exp_ctrl;
    chk({tag, "_idle"}, u.m_upload_state, 2'b00);
    u.v_m_upload_req = 1'b1;
    u.m_upload_flits = msg;
    u.m_upload_len   = len;
    step();
    if (hold) begin
      u.m_upload_flits = alt;
      u.m_upload_len   = alt_len;
    end else begin
      u.v_m_upload_req = 1'b0;
    end
    for (int k = 0; k < eff; k++) begin
      exp_ctrl = (k == 0) ? 2'b01 : (k == eff - 1) ? 2'b11 : 2'b10;
      chk($sformatf("%s_ack%0d", tag, k), u.m_upload_ack, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_v%0d", tag, k), u.v_OUT_flit_mem, 1'b1);
      chk($sformatf("%s_d%0d", tag, k), u.OUT_flit_mem, msg[16*k +: 16]);
      chk($sformatf("%s_c%0d", tag, k), u.OUT_flit_ctrl, exp_ctrl);
      chk($sformatf("%s_nd%0d", tag, k), u.m_upload_done, 1'b0);
      step();
    end
    chk({tag, "_done"}, u.m_upload_done, 1'b1);
    chk({tag, "_done_st"}, u.m_upload_state, 2'b10);
    chk({tag, "_done_v"}, u.v_OUT_flit_mem, 1'b0);
    chk({tag, "_done_c"}, u.OUT_flit_ctrl, 2'b00);
    step();
    chk({tag, "_back_idle"}, u.m_upload_state, 2'b00);
    chk({tag, "_done_once"}, u.m_upload_done, 1'b0);
  endtask

  initial begin
    logic [MSG_W-1:0] m;
    rst              = 1'b1;
    u.v_m_upload_req = 1'b0;
    u.m_upload_flits = '0;
    u.m_upload_len   = '0;
    u.net_rdy        = 1'b1;
    repeat (3) step();

    chk("rst_state", u.m_upload_state, 2'b00);
    chk("rst_v", u.v_OUT_flit_mem, 1'b0);
    chk("rst_d", u.OUT_flit_mem, 16'h0000);
    chk("rst_c", u.OUT_flit_ctrl, 2'b00);
    chk("rst_ack", u.m_upload_ack, 1'b0);
    chk("rst_done", u.m_upload_done, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_hold", u.m_upload_state, 2'b00);

    // full 11-flit message, 1000..100A
    run_msg("len11", build(16'h1000), 4'd11, 11, 1'b0, '0, '0);
    // length clamps
    run_msg("len0", build(16'h2000), 4'd0, 2, 1'b0, '0, '0);
    run_msg("len15", build(16'h3000), 4'd15, 11, 1'b0, '0, '0);
    // req held through busy with new data; second message follows after idle
    run_msg("holdA", build(16'h4000), 4'd3, 3, 1'b1, build(16'h5000), 4'd5);
    run_msg("holdB", build(16'h5000), 4'd5, 5, 1'b0, '0, '0);

    // reset after flit 3 of an 8-flit message
    m = build(16'h6000);
    u.v_m_upload_req = 1'b1;
    u.m_upload_flits = m;
    u.m_upload_len   = 4'd8;
    step();
    u.v_m_upload_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_d%0d", k), u.OUT_flit_mem, 16'h6000 + 16'(k));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", u.m_upload_state, 2'b00);
    chk("mid_rst_v", u.v_OUT_flit_mem, 1'b0);
    chk("mid_rst_d", u.OUT_flit_mem, 16'h0000);
    chk("mid_rst_c", u.OUT_flit_ctrl, 2'b00);
    chk("mid_rst_done", u.m_upload_done, 1'b0);
    step();
    chk("mid_rst_done2", u.m_upload_done, 1'b0);
    run_msg("post_rst", build(16'h7000), 4'd8, 8, 1'b0, '0, '0);

`ifdef M_UPLOAD_BACKPRESSURE_EN
    // head stalled 3 cycles by the ring
    m = '0;
    m[15:0]  = 16'hAAAA;
    m[31:16] = 16'hBBBB;
    u.v_m_upload_req = 1'b1;
    u.m_upload_flits = m;
    u.m_upload_len   = 4'd2;
    step();
    u.v_m_upload_req = 1'b0;
    u.net_rdy        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_stall_d%0d", i), u.OUT_flit_mem, 16'hAAAA);
      chk($sformatf("bp_stall_c%0d", i), u.OUT_flit_ctrl, 2'b01);
      step();
    end
    u.net_rdy = 1'b1;
    chk("bp_head_d", u.OUT_flit_mem, 16'hAAAA);
    chk("bp_head_c", u.OUT_flit_ctrl, 2'b01);
    step();
    chk("bp_tail_d", u.OUT_flit_mem, 16'hBBBB);
    chk("bp_tail_c", u.OUT_flit_ctrl, 2'b11);
    step();
    chk("bp_done", u.m_upload_done, 1'b1);
    step();
    chk("bp_idle", u.m_upload_state, 2'b00);
`else
    // net_rdy ignored: 4 flits back to back
    u.net_rdy = 1'b0;
    run_msg("nobp", build(16'h8000), 4'd4, 4, 1'b0, '0, '0);
    u.net_rdy = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
